pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central pipeline sequencer for the five-stage MIPS core. It replaces the uniform `!halt` enable tie-off with per-stage enables and bubble (flush) controls. It detects register and HI/LO read-after-write hazards in ID against producers in EX and MEM, since the datapath has no forwarding. It also squashes wrong-path instructions on taken branches and jumps, and owns the SYSCALL halt/GO resume sequence.

## Interface
- No parameters.
- `clk  in  1`: pipeline clock, rising edge.
- `CLR_n  in  1`: asynchronous reset, active-low.
- `rs_id, rt_id  in  5 each`: source register fields of the instruction in ID.
- `use_rs_id, use_rt_id  in  1 each`: the ID instruction reads rs or rt.
- `use_hilo_id  in  1`: the ID instruction reads HI or LO.
- `wb_ex, wb_mem  in  5 each`: destination register of the EX and MEM instructions.
- `regwrite_ex, regwrite_mem  in  1 each`: EX or MEM instruction writes the register file.
- `hilo_wr_ex, hilo_wr_mem  in  1 each`: EX or MEM instruction writes HI or LO.
- `jump_id  in  1`: JMP, JR or JAL resolved in ID.
- `branch_ex  in  1`: branch taken, resolved in EX.
- `halt_req  in  1`: SYSCALL in WB requests halt (level).
- `GO  in  1`: resume button, asynchronous to program flow.
- `PC_EN, EN1, EN2, EN3, EN4  out  1 each`: PC and IF/ID, ID/EX, EX/MEM, MEM/WB register enables.
- `bubble1, bubble2  out  1 each`: load a NOP into IF/ID or ID/EX on the next edge.
- `halted  out  1`: the pipeline is frozen.
- `stall_cnt, flush_cnt  out  16 each`: performance counters (see Configuration).

## Operation
- State machine states: RUN, HALT, RESUME. Reset enters RUN.
- Hazard terms (combinational):
  - haz_rs = use_rs_id & rs_id≠0 & ((regwrite_ex & rs_id==wb_ex) | (regwrite_mem & rs_id==wb_mem)).
  - haz_rt is the same expression with rt_id.
  - haz_hl = use_hilo_id & (hilo_wr_ex | hilo_wr_mem).
  - stall = haz_rs | haz_rt | haz_hl.
- WB producers are not hazards; the register file is write-before-read.
- RUN outputs, first match wins:
  1. halt_req: next state HALT. All enables 0, both bubbles 0.
  2. branch_ex: all enables 1, bubble1=1, bubble2=1. The redirect overrides any stall because the stalled instruction is on the wrong path.
  3. stall: PC_EN=0, EN1=0, EN2=EN3=EN4=1, bubble2=1, bubble1=0. jump_id is ignored while stalled, because JR may wait on rs.
  4. jump_id: all enables 1, bubble1=1.
  5. Otherwise: all enables 1, bubbles 0.
- HALT: all enables 0, bubbles 0, halted=1.
  - A GO rising edge (GO & !go_q, go_q registered each cycle) moves the FSM to RESUME.
  - GO already high on entry does not resume; a fresh edge is required.
- RESUME: lasts one cycle and ignores halt_req, letting the SYSCALL leave WB. Outputs follow RUN rules 2–5. Next state RUN.
- halted = (state==HALT).

## Timing
- Enables and bubbles are combinational from the current state and inputs, so they act on the same edge the condition is seen.
- Stall lengths, measured from when the consumer enters ID:
  - Producer in EX: 2 stall cycles.
  - Producer in MEM: 1 stall cycle.
- Taken branch: 2 squashed instructions. Jump: 1 squashed instruction.
- Halt entry: halted asserts on the edge after halt_req is seen in RUN, and the pipeline is frozen that same cycle.
- Halt exit: halted=0 one cycle after the GO edge cycle.
- Reset values while CLR_n=0:
  - State RUN; go_q=0.
  - PC_EN=EN1..EN4=0, bubble1=bubble2=0, halted=0.
  - stall_cnt=flush_cnt=0.
- Reset asserted mid-HALT or mid-stall returns to RUN. No pending GO edge survives reset.
- halt_req together with branch_ex: halt wins and nothing is squashed. The branch is re-evaluated after RESUME because EX contents are held.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - stall_cnt increments on every RUN/RESUME cycle with stall and no branch_ex.
  - flush_cnt increments on every cycle with bubble1=1.
  - Both counters are 16-bit, saturate at 0xFFFF, and do not count in HALT.
- Undefined: both counters are tied to 0 and no counter flops are built.

## Test plan
- Sequence `lw $2,0($0)` then `add $3,$2,$2`: with the add in ID, 2 cycles of PC_EN=0/EN1=0/bubble2=1; the add issues on the 3rd cycle; stall_cnt=2.
- `add $4,$0,$0` in ID while the MEM instruction writes $0 with regwrite_mem=1: no stall; all enables 1.
- branch_ex=1 while stall=1: PC_EN=EN1=1, bubble1=bubble2=1; flush_cnt increments by 1.
- jump_id=1 with haz_rs on the JR source: stall only, bubble1=0, until the hazard clears; then bubble1=1 for one cycle.
- halt_req=1 with GO held high:
  - halted=1 and all enables 0.
  - GO low for 3 cycles then high: RESUME for one cycle with halt_req still 1, then RUN with halted=0.
- CLR_n pulsed low during HALT: all outputs take their reset values immediately; after release the FSM is in RUN with enables 1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: per-stage enables and bubble controls for the
// five-stage MIPS core. It detects RAW hazards against EX/MEM producers
// (there is no forwarding), squashes the wrong path on taken branches and
// jumps, and sequences the SYSCALL halt / GO resume.
// Optional feature: define HAZ_PERF_CNT_EN to build the stall/flush counters.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        CLR_n,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        use_rs_id,
  input  logic        use_rt_id,
  input  logic        use_hilo_id,
  input  logic [4:0]  wb_ex,
  input  logic [4:0]  wb_mem,
  input  logic        regwrite_ex,
  input  logic        regwrite_mem,
  input  logic        hilo_wr_ex,
  input  logic        hilo_wr_mem,
  input  logic        jump_id,
  input  logic        branch_ex,
  input  logic        halt_req,
  input  logic        GO,
  output logic        PC_EN,
  output logic        EN1,
  output logic        EN2,
  output logic        EN3,
  output logic        EN4,
  output logic        bubble1,
  output logic        bubble2,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, HALT, RESUME} state_t;

  state_t state_q, state_d;
  logic   go_q;
  logic   haz_rs, haz_rt, haz_hl, stall;
  logic   f_pc, f_en1, f_b1, f_b2, f_stall;
  logic   stall_hit;

  // RAW hazard detection against EX and MEM producers; $0 never hazards
  always_comb begin
    haz_rs = use_rs_id && (rs_id != 5'd0) &&
             ((regwrite_ex && (rs_id == wb_ex)) || (regwrite_mem && (rs_id == wb_mem)));
    haz_rt = use_rt_id && (rt_id != 5'd0) &&
             ((regwrite_ex && (rt_id == wb_ex)) || (regwrite_mem && (rt_id == wb_mem)));
    haz_hl = use_hilo_id && (hilo_wr_ex || hilo_wr_mem);
    stall  = haz_rs || haz_rt || haz_hl;
  end

  // Flow-control decode shared by RUN and RESUME: branch beats stall beats jump
  always_comb begin
    f_pc    = 1'b1;
    f_en1   = 1'b1;
    f_b1    = 1'b0;
    f_b2    = 1'b0;
    f_stall = 1'b0;
    if (branch_ex) begin
      f_b1 = 1'b1;
      f_b2 = 1'b1;
    end else if (stall) begin
      f_pc    = 1'b0;
      f_en1   = 1'b0;
      f_b2    = 1'b1;
      f_stall = 1'b1;
    end else if (jump_id) begin
      f_b1 = 1'b1;
    end
  end

  // Next-state and output decode; outputs forced to reset values while CLR_n is low
  always_comb begin
    state_d   = state_q;
    PC_EN     = 1'b0;
    EN1       = 1'b0;
    EN2       = 1'b0;
    EN3       = 1'b0;
    EN4       = 1'b0;
    bubble1   = 1'b0;
    bubble2   = 1'b0;
    stall_hit = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else begin
          PC_EN     = f_pc;
          EN1       = f_en1;
          {EN2, EN3, EN4} = 3'b111;
          bubble1   = f_b1;
          bubble2   = f_b2;
          stall_hit = f_stall;
        end
      end
      RESUME: begin
        state_d   = RUN;
        PC_EN     = f_pc;
        EN1       = f_en1;
        {EN2, EN3, EN4} = 3'b111;
        bubble1   = f_b1;
        bubble2   = f_b2;
        stall_hit = f_stall;
      end
      HALT: begin
        if (GO && !go_q) state_d = RESUME;
      end
      default: state_d = RUN;
    endcase
    if (!CLR_n) begin
      PC_EN     = 1'b0;
      EN1       = 1'b0;
      EN2       = 1'b0;
      EN3       = 1'b0;
      EN4       = 1'b0;
      bubble1   = 1'b0;
      bubble2   = 1'b0;
      stall_hit = 1'b0;
    end
  end

  assign halted = (state_q == HALT);

  // State register and GO edge-detect flop
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= RUN;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= GO;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating performance counters; neither can count in HALT since
  // stall_hit and bubble1 are only raised in RUN/RESUME
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_hit && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (bubble1 && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// constant expectations plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        CLR_n;
  logic [4:0]  rs_id, rt_id, wb_ex, wb_mem;
  logic        use_rs_id, use_rt_id, use_hilo_id;
  logic        regwrite_ex, regwrite_mem, hilo_wr_ex, hilo_wr_mem;
  logic        jump_id, branch_ex, halt_req, GO;
  logic        PC_EN, EN1, EN2, EN3, EN4, bubble1, bubble2, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [7:0]  obs;

  int checks = 0;
  int errors = 0;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Model: mode flags, GO history, counters
  bit m_halt, m_res, m_goq;
  int m_sc, m_fc;

  pipeline_hazard_ctrl dut (
    .clk(clk), .CLR_n(CLR_n),
    .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .use_hilo_id(use_hilo_id),
    .wb_ex(wb_ex), .wb_mem(wb_mem),
    .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem),
    .hilo_wr_ex(hilo_wr_ex), .hilo_wr_mem(hilo_wr_mem),
    .jump_id(jump_id), .branch_ex(branch_ex), .halt_req(halt_req), .GO(GO),
    .PC_EN(PC_EN), .EN1(EN1), .EN2(EN2), .EN3(EN3), .EN4(EN4),
    .bubble1(bubble1), .bubble2(bubble2), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign obs = {PC_EN, EN1, EN2, EN3, EN4, bubble1, bubble2, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector {PC_EN,EN1,EN2,EN3,EN4,bubble1,bubble2,halted}
  localparam logic [7:0] V_FREEZE = 8'b00000_00_0;
  localparam logic [7:0] V_HALTED = 8'b00000_00_1;
  localparam logic [7:0] V_FLOW   = 8'b11111_00_0;
  localparam logic [7:0] V_STALL  = 8'b00111_01_0;
  localparam logic [7:0] V_BRANCH = 8'b11111_11_0;
  localparam logic [7:0] V_JUMP   = 8'b11111_10_0;

  task automatic idle_inputs();
    rs_id = 0; rt_id = 0; wb_ex = 0; wb_mem = 0;
    use_rs_id = 0; use_rt_id = 0; use_hilo_id = 0;
    regwrite_ex = 0; regwrite_mem = 0; hilo_wr_ex = 0; hilo_wr_mem = 0;
    jump_id = 0; branch_ex = 0; halt_req = 0; GO = 0;
  endtask

  // Behavioural view: ID must wait if any value it reads is still being
  // produced by an instruction in EX or MEM (register $0 is never produced).
  task automatic model_expect(output logic [7:0] e, output bit st);
    bit waits;
    logic [4:0] src [2];
    bit         used [2];
    logic [4:0] dst [2];
    bit         wr [2];
    src[0] = rs_id; used[0] = use_rs_id;
    src[1] = rt_id; used[1] = use_rt_id;
    dst[0] = wb_ex; wr[0] = regwrite_ex;
    dst[1] = wb_mem; wr[1] = regwrite_mem;
    waits = use_hilo_id && (hilo_wr_ex || hilo_wr_mem);
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 2; p++)
        if (used[s] && wr[p] && src[s] != 0 && src[s] == dst[p]) waits = 1;
    st = 0;
    if (m_halt)                 e = V_HALTED;
    else if (!m_res && halt_req) e = V_FREEZE;
    else if (branch_ex)         e = V_BRANCH;
    else if (waits) begin       e = V_STALL; st = 1; end
    else if (jump_id)           e = V_JUMP;
    else                        e = V_FLOW;
  endtask

  task automatic model_commit();
    logic [7:0] e;
    bit st;
    model_expect(e, st);
    if (st && m_sc < 65535) m_sc++;
    if (e[2] && m_fc < 65535) m_fc++;
    if (m_halt) begin
      if (GO && !m_goq) begin m_halt = 0; m_res = 1; end
    end else if (m_res) m_res = 0;
    else if (halt_req) m_halt = 1;
    m_goq = GO;
  endtask

  task automatic model_reset();
    m_halt = 0; m_res = 0; m_goq = 0; m_sc = 0; m_fc = 0;
  endtask

  // Advance one clock: account the cycle in the model, then move to edge+1
  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    CLR_n = 0;
    model_reset();
    rs_id = 3; use_rs_id = 1; wb_ex = 3; regwrite_ex = 1; jump_id = 1; GO = 1;
    #2;
    checks++;
    if (obs !== V_FREEZE) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, V_FREEZE); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    CLR_n = 1;
    idle_inputs();
    #2;
    checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL reset_release: got %b want %b", obs, V_FLOW); end
    tick();
  endtask

  task automatic test_load_use();
    logic [15:0] sc0;
    sc0 = stall_cnt;
    idle_inputs();
    rs_id = 2; rt_id = 2; use_rs_id = 1; use_rt_id = 1; wb_ex = 2; regwrite_ex = 1;
    #2; checks++;
    if (obs !== V_STALL) begin errors++; $display("FAIL load_use_ex: got %b want %b", obs, V_STALL); end
    tick();
    regwrite_ex = 0; wb_ex = 0; wb_mem = 2; regwrite_mem = 1;
    #2; checks++;
    if (obs !== V_STALL) begin errors++; $display("FAIL load_use_mem: got %b want %b", obs, V_STALL); end
    tick();
    regwrite_mem = 0;
    #2; checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL load_use_issue: got %b want %b", obs, V_FLOW); end
    checks++;
    if (stall_cnt !== (PERF ? sc0 + 16'd2 : 16'd0)) begin
      errors++; $display("FAIL load_use_stall_cnt: got %0d want %0d", stall_cnt, PERF ? sc0 + 16'd2 : 16'd0);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    use_rs_id = 1; use_rt_id = 1; wb_mem = 0; regwrite_mem = 1; wb_ex = 0; regwrite_ex = 1;
    #2; checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL zero_reg: got %b want %b", obs, V_FLOW); end
    tick();
  endtask

  task automatic test_branch_over_stall();
    logic [15:0] fc0;
    idle_inputs();
    fc0 = flush_cnt;
    rt_id = 7; use_rt_id = 1; wb_ex = 7; regwrite_ex = 1; branch_ex = 1;
    #2; checks++;
    if (obs !== V_BRANCH) begin errors++; $display("FAIL branch_over_stall: got %b want %b", obs, V_BRANCH); end
    tick();
    idle_inputs();
    #2; checks++;
    if (flush_cnt !== (PERF ? fc0 + 16'd1 : 16'd0)) begin
      errors++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_cnt, PERF ? fc0 + 16'd1 : 16'd0);
    end
    tick();
  endtask

  task automatic test_jump_stall();
    idle_inputs();
    jump_id = 1; use_rs_id = 1; rs_id = 5; wb_ex = 5; regwrite_ex = 1;
    #2; checks++;
    if (obs !== V_STALL) begin errors++; $display("FAIL jr_stall_ex: got %b want %b", obs, V_STALL); end
    tick();
    regwrite_ex = 0; wb_mem = 5; regwrite_mem = 1;
    #2; checks++;
    if (obs !== V_STALL) begin errors++; $display("FAIL jr_stall_mem: got %b want %b", obs, V_STALL); end
    tick();
    regwrite_mem = 0;
    #2; checks++;
    if (obs !== V_JUMP) begin errors++; $display("FAIL jr_squash: got %b want %b", obs, V_JUMP); end
    tick();
    jump_id = 0;
    #2; checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL jr_after: got %b want %b", obs, V_FLOW); end
    tick();
  endtask

  task automatic test_halt_go();
    idle_inputs();
    halt_req = 1; GO = 1;
    #2; checks++;
    if (obs !== V_FREEZE) begin errors++; $display("FAIL halt_entry: got %b want %b", obs, V_FREEZE); end
    tick();
    #2; checks++;
    if (obs !== V_HALTED) begin errors++; $display("FAIL halt_go_held: got %b want %b", obs, V_HALTED); end
    tick();
    GO = 0;
    for (int i = 0; i < 3; i++) begin
      #2; checks++;
      if (obs !== V_HALTED) begin errors++; $display("FAIL halt_go_low%0d: got %b want %b", i, obs, V_HALTED); end
      tick();
    end
    GO = 1;
    #2; checks++;
    if (obs !== V_HALTED) begin errors++; $display("FAIL halt_go_edge: got %b want %b", obs, V_HALTED); end
    tick();
    #2; checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL resume_cycle: got %b want %b", obs, V_FLOW); end
    tick();
    halt_req = 0;
    #2; checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL run_after_resume: got %b want %b", obs, V_FLOW); end
    tick();
  endtask

  task automatic test_halt_with_branch();
    idle_inputs();
    halt_req = 1; branch_ex = 1;
    #2; checks++;
    if (obs !== V_FREEZE) begin errors++; $display("FAIL halt_beats_branch: got %b want %b", obs, V_FREEZE); end
    tick();
    GO = 1;
    tick();
    #2; checks++;
    if (obs !== V_BRANCH) begin errors++; $display("FAIL branch_after_resume: got %b want %b", obs, V_BRANCH); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_halt();
    idle_inputs();
    halt_req = 1;
    tick();
    #2; checks++;
    if (obs !== V_HALTED) begin errors++; $display("FAIL pre_reset_halted: got %b want %b", obs, V_HALTED); end
    GO = 1;
    CLR_n = 0;
    model_reset();
    #1; checks++;
    if (obs !== V_FREEZE || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_in_halt: got %b %0d %0d want %b 0 0", obs, stall_cnt, flush_cnt, V_FREEZE);
    end
    @(posedge clk); #1;
    CLR_n = 1;
    halt_req = 0;
    #2; checks++;
    if (obs !== V_FLOW) begin errors++; $display("FAIL reset_in_halt_release: got %b want %b", obs, V_FLOW); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] e;
    bit st;
    for (int n = 0; n < 400; n++) begin
      rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
      wb_ex = 5'($urandom_range(0, 3)); wb_mem = 5'($urandom_range(0, 3));
      use_rs_id = 1'($urandom); use_rt_id = 1'($urandom);
      regwrite_ex = 1'($urandom); regwrite_mem = 1'($urandom);
      use_hilo_id = ($urandom_range(0, 3) == 0);
      hilo_wr_ex = ($urandom_range(0, 3) == 0); hilo_wr_mem = ($urandom_range(0, 3) == 0);
      jump_id = ($urandom_range(0, 3) == 0);
      branch_ex = ($urandom_range(0, 6) == 0);
      halt_req = ($urandom_range(0, 11) == 0);
      GO = 1'($urandom);
      #2;
      model_expect(e, st);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL random_outputs[%0d]: got %b want %b", n, obs, e); end
      checks++;
      if (stall_cnt !== (PERF ? 16'(m_sc) : 16'd0) || flush_cnt !== (PERF ? 16'(m_fc) : 16'd0)) begin
        errors++;
        $display("FAIL random_counters[%0d]: got %0d/%0d want %0d/%0d", n, stall_cnt, flush_cnt,
                 PERF ? m_sc : 0, PERF ? m_fc : 0);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    CLR_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_over_stall();
    test_jump_stall();
    test_halt_go();
    test_halt_with_branch();
    test_reset_in_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
